level_detector: RTL and testbench

- Audio-side producer for the front-panel LED bar.
- Consumes a stream of signed PCM samples and produces a peak-hold, exponentially-released level word plus a one-cycle transient (beat) pulse.
- `level` feeds the LED display's `data_in`; `transient` feeds its `transient` input.
- Sits between the audio sample path and the LED display, in the same clock domain.

---
 rtl/level_detector.sv | 135 +++++++++++++
 tb/tb_level_detector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/level_detector.sv
// Peak-hold, exponentially released level meter with a transient (beat) detector.
// Two-stage pipeline: saturating magnitude, then envelope/average/transient FSM.
module level_detector #(
  parameter int                      DATA_IN_BITS   = 24,
  parameter int                      RELEASE_SHIFT  = 10,
  parameter int                      AVG_SHIFT      = 14,
  parameter int                      THRESH_NUM     = 3,
  parameter int                      THRESH_SHIFT   = 1,
  parameter logic [DATA_IN_BITS-1:0] MIN_LEVEL      = 24'h080000,
  parameter int                      HOLDOFF_CYCLES = 4000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_IN_BITS-1:0] sample,
  input  logic                    sample_valid,
  output logic [DATA_IN_BITS-1:0] level,
  output logic                    level_valid,
  output logic                    transient,
  output logic                    fsm_state
);

  // Handshake: sample is taken on every clk edge where sample_valid is high
  // (no ready, no backpressure); level_valid pulses for one cycle two edges
  // later, and transient for that sample rises in that same cycle.

  localparam int N    = DATA_IN_BITS;
  localparam int AW   = N + AVG_SHIFT;
  localparam int CW   = N + THRESH_SHIFT + 2;
  localparam int CNTW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic {
    ARMED   = 1'b0,
    HOLDOFF = 1'b1
  } state_t;

  logic [N-1:0]    mag;
  logic [N-1:0]    abs_r;
  logic            v1;

  logic [N-1:0]    env;
  logic [N-1:0]    env_dec;
  logic [N-1:0]    env_new;
  logic [AW-1:0]   avg_acc;
  logic [AW-1:0]   avg_acc_next;
  logic [N-1:0]    avg;
  logic [CW-1:0]   lhs;
  logic [CW-1:0]   rhs;
  logic            cond;

  state_t          state;
  state_t          state_next;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_next;
  logic            transient_next;

  // Most negative input has no positive twin; clamp it to the largest positive.
  always_comb begin
    mag = sample;
    if (sample[N-1]) begin
      if (sample[N-2:0] == '0) mag = {1'b0, {(N-1){1'b1}}};
      else                     mag = -sample;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      abs_r <= '0;
      v1    <= 1'b0;
    end else begin
      v1 <= sample_valid;
      if (sample_valid) abs_r <= {mag[N-2:0], 1'b0};
    end
  end

  // Instant attack; proportional release that degrades to -1 steps near zero.
  always_comb begin
    env_dec = env >> RELEASE_SHIFT;
    if (abs_r >= env)         env_new = abs_r;
    else if (env_dec != '0)   env_new = env - env_dec;
    else if (env != '0)       env_new = env - N'(1);
    else                      env_new = '0;
  end

  assign avg          = avg_acc[AW-1:AVG_SHIFT];
  assign avg_acc_next = avg_acc - (avg_acc >> AVG_SHIFT) + AW'(env_new);

  // Compare against the average before this sample is folded in.
  assign lhs  = CW'(env_new) << THRESH_SHIFT;
  assign rhs  = CW'(avg) * CW'(THRESH_NUM);
  assign cond = (lhs > rhs) && (env_new >= MIN_LEVEL);

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    transient_next = 1'b0;
    case (state)
      ARMED: begin
        if (v1 && cond) begin
          transient_next = 1'b1;
          cnt_next       = CNTW'(HOLDOFF_CYCLES - 1);
          state_next     = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cnt == '0) state_next = ARMED;
        else           cnt_next   = cnt - CNTW'(1);
      end
      default: state_next = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      env         <= '0;
      avg_acc     <= '0;
      level_valid <= 1'b0;
      transient   <= 1'b0;
      state       <= ARMED;
      cnt         <= '0;
    end else begin
      level_valid <= v1;
      transient   <= transient_next;
      state       <= state_next;
      cnt         <= cnt_next;
      if (v1) begin
        env     <= env_new;
        avg_acc <= avg_acc_next;
      end
    end
  end

  assign level     = env;
  assign fsm_state = state;

endmodule

// File: tb/tb_level_detector.sv
// Scoreboard bench for level_detector: two instances (long-average/holdoff-16
// and fast-average/unit-release/no-minimum) driven from directed vectors.
module tb_level_detector;

  localparam int N  = 24;
  localparam int EW = 32 + 2 + 1 + N;
  localparam logic [1:0] M_EXACT = 2'd0;
  localparam logic [1:0] M_DECAY = 2'd1;
  localparam logic [N-1:0] FS_POS = 24'h7FFFFF;
  localparam logic [N-1:0] FS_LVL = 24'hFFFFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a = 1'b0, rst_b = 1'b0;
  logic [N-1:0] sample_a = '0, sample_b = '0;
  logic         valid_a = 1'b0, valid_b = 1'b0;
  logic [N-1:0] level_a, level_b;
  logic         lv_a, lv_b, tr_a, tr_b, st_a, st_b;

  int unsigned  cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [N-1:0] prev_level [2];

  level_detector #(.HOLDOFF_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst_a), .sample(sample_a), .sample_valid(valid_a),
    .level(level_a), .level_valid(lv_a), .transient(tr_a), .fsm_state(st_a)
  );

  level_detector #(.RELEASE_SHIFT(24), .AVG_SHIFT(2), .MIN_LEVEL(24'h000000),
                   .HOLDOFF_CYCLES(16)) dut_b (
    .clk(clk), .rst(rst_b), .sample(sample_b), .sample_valid(valid_b),
    .level(level_b), .level_valid(lv_b), .transient(tr_b), .fsm_state(st_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor(input int d, input logic [N-1:0] level, input logic lv, input logic tr);
    logic [EW-1:0] e;
    logic [31:0]   due;
    int            qs;
    qs = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (tr && !lv) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d_stray_transient: transient=1 without level_valid (cycle %0d)", d, cyc);
    end
    if (lv) begin
      if (qs == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d_unexpected_valid: level=%h, nothing expected (cycle %0d)", d, level, cyc);
      end else begin
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check($sformatf("dut%0d_latency", d), cyc, e[EW-1 -: 32]);
        if (e[N+2 -: 2] == M_EXACT) begin
          check($sformatf("dut%0d_level", d), 32'(level), 32'(e[N-1:0]));
        end else begin
          n_checks++;
          if (!(level < prev_level[d])) begin
            n_fail++;
            $display("FAIL dut%0d_decay: got %0h, required below %0h", d, level, prev_level[d]);
          end
        end
        check($sformatf("dut%0d_transient", d), 32'(tr), 32'(e[N]));
        prev_level[d] = level;
      end
    end else if (qs != 0) begin
      e = (d == 0) ? exp_q0[0] : exp_q1[0];
      due = e[EW-1 -: 32];
      if (due <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d_timeout: level_valid=0, required 1 at cycle %0d", d, due);
        if (d == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0, level_a, lv_a, tr_a);
    monitor(1, level_b, lv_b, tr_b);
  end

  // ---------------- drivers ----------------
  task automatic set_in(input int d, input logic [N-1:0] s, input logic v);
    if (d == 0) begin sample_a = s; valid_a = v; end
    else        begin sample_b = s; valid_b = v; end
  endtask

  task automatic drive(input int d, input logic [N-1:0] s, input logic [1:0] mode,
                       input logic [N-1:0] lvl, input logic tr);
    logic [31:0] due;
    @(posedge clk);
    #1;
    set_in(d, s, 1'b1);
    due = cyc + 32'd2;
    if (d == 0) exp_q0.push_back({due, mode, tr, lvl});
    else        exp_q1.push_back({due, mode, tr, lvl});
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      set_in(d, '0, 1'b0);
    end
  endtask

  task automatic do_reset(input int d);
    @(posedge clk);
    #1;
    if (d == 0) begin exp_q0.delete(); rst_a = 1'b0; end
    else        begin exp_q1.delete(); rst_b = 1'b0; end
    for (int i = 0; i < 4; i++) begin
      set_in(d, N'($urandom_range(32'h00FFFFFF, 0)), i[0]);
      @(negedge clk);
      check($sformatf("dut%0d_rst_level", d), 32'((d == 0) ? level_a : level_b), 32'h0);
      check($sformatf("dut%0d_rst_valid", d), 32'((d == 0) ? lv_a : lv_b), 32'h0);
      check($sformatf("dut%0d_rst_transient", d), 32'((d == 0) ? tr_a : tr_b), 32'h0);
      @(posedge clk);
      #1;
    end
    set_in(d, '0, 1'b0);
    if (d == 0) rst_a = 1'b1;
    else        rst_b = 1'b1;
    @(negedge clk);
    check($sformatf("dut%0d_armed_after_reset", d), 32'((d == 0) ? st_a : st_b), 32'h0);
    prev_level[d] = '0;
  endtask

  // Two full-scale samples then six zeros; first pulse lands on the first sample.
  task automatic burst_then_zeros;
    drive(0, FS_POS, M_EXACT, FS_LVL, 1'b1);
    drive(0, FS_POS, M_EXACT, FS_LVL, 1'b0);
    drive(0, '0, M_EXACT, 24'hFFBFFF, 1'b0);
    repeat (5) drive(0, '0, M_DECAY, '0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(0);
    do_reset(1);

    // Step from silence, then release.
    repeat (64) drive(0, '0, M_EXACT, '0, 1'b0);
    drive(0, FS_POS, M_EXACT, FS_LVL, 1'b1);
    drive(0, '0, M_EXACT, 24'hFFBFFF, 1'b0);
    repeat (10) drive(0, '0, M_DECAY, '0, 1'b0);
    idle(0, 30);

    // Second burst 8 cycles after the pulse: suppressed.
    do_reset(0);
    burst_then_zeros();
    drive(0, FS_POS, M_EXACT, FS_LVL, 1'b0);
    drive(0, FS_POS, M_EXACT, FS_LVL, 1'b0);
    idle(0, 30);

    // Update on the re-arm cycle gives no pulse; the next one does.
    do_reset(0);
    burst_then_zeros();
    idle(0, 8);
    drive(0, FS_POS, M_EXACT, FS_LVL, 1'b0);
    drive(0, '0, M_EXACT, 24'hFFBFFF, 1'b1);
    idle(0, 30);

    // Second burst 20 cycles after the pulse: fires.
    do_reset(0);
    burst_then_zeros();
    idle(0, 12);
    drive(0, FS_POS, M_EXACT, FS_LVL, 1'b1);
    idle(0, 30);

    // Saturation, then reset mid-holdoff with a sample in flight.
    do_reset(0);
    drive(0, 24'h800000, M_EXACT, FS_LVL, 1'b1);
    idle(0, 3);
    @(negedge clk);
    check("dut0_in_holdoff", 32'(st_a), 32'h1);
    drive(0, FS_POS, M_EXACT, FS_LVL, 1'b0);
    do_reset(0);
    repeat (4) drive(0, '0, M_EXACT, '0, 1'b0);
    drive(0, FS_POS, M_EXACT, FS_LVL, 1'b1);
    idle(0, 30);

    // Minimum-level gate, negative inputs, and the exact-minimum boundary.
    do_reset(0);
    drive(0, 24'h020000, M_EXACT, 24'h040000, 1'b0);
    drive(0, 24'hFE0000, M_EXACT, 24'h040000, 1'b0);
    drive(0, 24'hFFFFFF, M_EXACT, 24'h03FF00, 1'b0);
    drive(0, 24'h040000, M_EXACT, 24'h080000, 1'b1);
    idle(0, 6);

    // Unit-step release down to zero.
    do_reset(1);
    drive(1, 24'h000003, M_EXACT, 24'h000006, 1'b1);
    for (int i = 5; i >= 0; i--) drive(1, '0, M_EXACT, N'(i), 1'b0);
    drive(1, '0, M_EXACT, '0, 1'b0);
    drive(1, '0, M_EXACT, '0, 1'b0);
    idle(1, 6);

    // Threshold: average settled at 0x100000, level just below the ratio.
    do_reset(1);
    drive(1, 24'h080000, M_EXACT, 24'h100000, 1'b1);
    repeat (199) drive(1, 24'h080000, M_EXACT, 24'h100000, 1'b0);
    drive(1, 24'h0BFFFF, M_EXACT, 24'h17FFFE, 1'b0);
    idle(1, 6);

    // Threshold: same settling, level just above the ratio.
    do_reset(1);
    drive(1, 24'h080000, M_EXACT, 24'h100000, 1'b1);
    repeat (199) drive(1, 24'h080000, M_EXACT, 24'h100000, 1'b0);
    drive(1, 24'h0C0001, M_EXACT, 24'h180002, 1'b1);
    idle(1, 6);

    idle(0, 4);
    check("dut0_pending", exp_q0.size(), 32'h0);
    check("dut1_pending", exp_q1.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
